// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants for the double-dabble converter and the display stage
// that consumes its BCD output.
//   DIGIT_W      : bits per BCD digit
//   ADJ_THRESH   : a digit at or above this value is adjusted before a shift
//   ADJ_ADD      : amount added by the adjust step
//   ADJ_INVALID  : first code that never appears in a legal accumulator
//   state_t      : converter sequencing states
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] ADJ_THRESH  = 4'd5;
    localparam logic [3:0] ADJ_ADD     = 4'd3;
    localparam logic [3:0] ADJ_INVALID = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational add-3 cell applied to one BCD digit before each shift.
//   din  : current accumulator digit
//   dout : adjusted digit
// Mapping: 0..4 pass through, 5..12 get +3, 13..15 give 0. Codes 13..15
// cannot occur in a running conversion; forcing them to 0 keeps the cell
// fully specified.
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADJ_INVALID) begin
            dout = '0;
        end else if (din >= ADJ_THRESH) begin
            dout = din + ADJ_ADD;
        end
    end

endmodule : bcd_digit_adj

// File: rtl/bcd_dd_seq.sv
// ---------------------------------------------------------------------------
// bcd_dd_seq
// Sequential double-dabble binary-to-BCD converter. One shift per clock,
// BIN_W+1 cycles from accepted start to the done pulse.
//
// Parameters:
//   BIN_W  : binary operand width (1..32)
//   DIGITS : number of BCD digits produced (>=1)
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request pulse, only looked at while busy=0
//   bin    : operand, captured on an accepted start
//   busy   : conversion in progress
//   done   : one-cycle pulse when bcd/ovf have been updated
//   bcd    : packed result, digit 0 in [3:0]
//   ovf    : value did not fit in DIGITS digits (bcd holds the low digits)
//   blank  : (BCD_DD_BLANK_EN only) leading-zero blanking flags per digit
//
// Optional feature macro: BCD_DD_BLANK_EN adds the blank output.
//
// State table:
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one adjust+shift per cycle, cnt counts remaining shifts
//   DONE  | publish accumulator to bcd/ovf, pulse done, drop busy
// ---------------------------------------------------------------------------
module bcd_dd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      ovf
`ifdef BCD_DD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 1 || BIN_W > 32 || DIGITS < 1) begin : g_param_check
        $fatal(1, "bcd_dd_seq: illegal parameters BIN_W=%0d DIGITS=%0d", BIN_W, DIGITS);
    end

    state_t             state;
    logic [BIN_W-1:0]   bin_sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic               ovf_acc;
    logic [CNT_W-1:0]   cnt;

    // Per-digit adjust applied to the whole accumulator in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc[g*DIGIT_W +: DIGIT_W]),
            .dout (acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD_DD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // Walk from the top digit down; a digit is blanked only while every
    // digit from it upward is zero. Digit 0 always shows.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (acc[i*DIGIT_W +: DIGIT_W] == '0);
            blank_nxt[i] = zero_above & ~ovf_acc;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bin_sr  <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
`ifdef BCD_DD_BLANK_EN
            blank   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The MSB of the adjusted top digit falls off the end;
                    // any 1 lost there means the value needed more digits.
                    acc     <= {acc_adj[ACC_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr  <= bin_sr << 1;
                    ovf_acc <= ovf_acc | acc_adj[ACC_W-1];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= acc;
                    ovf   <= ovf_acc;
`ifdef BCD_DD_BLANK_EN
                    blank <= blank_nxt;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : bcd_dd_seq

// File: tb/tb_bcd_dd_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_dd_seq
// Two converters side by side (DIGITS=3 and DIGITS=2, BIN_W=8), compared
// every cycle against an arithmetic model, plus directed literal checks.
// Builds with or without BCD_DD_BLANK_EN.
// ---------------------------------------------------------------------------
module tb_bcd_dd_seq;

    localparam int BIN_W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st [2];
    logic [7:0] bv [2];

    logic        busy0, done0, ovf0;
    logic [11:0] bcd0;
    logic        busy1, done1, ovf1;
    logic [7:0]  bcd1;
`ifdef BCD_DD_BLANK_EN
    logic [2:0]  blank0;
    logic [1:0]  blank1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_dd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (st[0]),
        .bin   (bv[0]),
        .busy  (busy0),
        .done  (done0),
        .bcd   (bcd0),
        .ovf   (ovf0)
`ifdef BCD_DD_BLANK_EN
        ,
        .blank (blank0)
`endif
    );

    bcd_dd_seq #(.BIN_W(BIN_W), .DIGITS(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (st[1]),
        .bin   (bv[1]),
        .busy  (busy1),
        .done  (done1),
        .bcd   (bcd1),
        .ovf   (ovf1)
`ifdef BCD_DD_BLANK_EN
        ,
        .blank (blank1)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [11:0] bcd_of(input int v, input int nd);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [2:0] blank_of(input int v, input int nd);
        logic [2:0] r;
        r = '0;
        if (v < pow10(nd)) begin
            for (int i = 1; i < nd; i++) r[i] = (v < pow10(i));
        end
        return r;
    endfunction

    function automatic int ndig(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    logic        m_busy  [2];
    logic        m_done  [2];
    logic        m_ovf   [2];
    logic [11:0] m_bcd   [2];
    logic [2:0]  m_blank [2];
    int          m_left  [2];
    int          m_val   [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k]  <= 1'b0;
                m_done[k]  <= 1'b0;
                m_ovf[k]   <= 1'b0;
                m_bcd[k]   <= '0;
                m_blank[k] <= '0;
                m_left[k]  <= 0;
                m_val[k]   <= 0;
            end else begin
                m_done[k] <= 1'b0;
                if (!m_busy[k]) begin
                    if (st[k]) begin
                        m_busy[k] <= 1'b1;
                        m_left[k] <= BIN_W + 1;
                        m_val[k]  <= int'(bv[k]);
                    end
                end else if (m_left[k] == 1) begin
                    m_busy[k]  <= 1'b0;
                    m_done[k]  <= 1'b1;
                    m_bcd[k]   <= bcd_of(m_val[k], ndig(k));
                    m_ovf[k]   <= (m_val[k] >= pow10(ndig(k)));
                    m_blank[k] <= blank_of(m_val[k], ndig(k));
                    m_left[k]  <= 0;
                end else begin
                    m_left[k] <= m_left[k] - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy0", busy0, m_busy[0]);
        chk("done0", done0, m_done[0]);
        chk("bcd0",  bcd0,  m_bcd[0]);
        chk("ovf0",  ovf0,  m_ovf[0]);
        chk("busy1", busy1, m_busy[1]);
        chk("done1", done1, m_done[1]);
        chk("bcd1",  bcd1,  m_bcd[1]);
        chk("ovf1",  ovf1,  m_ovf[1]);
`ifdef BCD_DD_BLANK_EN
        chk("blank0", blank0, m_blank[0]);
        chk("blank1", blank1, m_blank[1][1:0]);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_now(input int k, input int v);
        st[k] = 1'b1;
        bv[k] = 8'(v);
        @(negedge clk);
        st[k] = 1'b0;
        bv[k] = 8'($urandom);
    endtask

    task automatic wait_done(input int k, output int c);
        logic seen;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            seen = (k == 0) ? done0 : done1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout dut%0d: no done within %0d cycles", k, c);
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done0) cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int nd;

        rst_n = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0;
        bv[0] = '0;   bv[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_bcd",  bcd0,  0);
        chk("rst_ovf",  ovf0,  0);
        rst_n = 1'b1;
        @(negedge clk);

        // 255: nine edges to done
        start_now(0, 255);
        wait_done(0, c);
        chk("lat_255", c, 9);
        chk("bcd_255", bcd0, 12'h255);
        chk("ovf_255", ovf0, 0);

        // 0 then 99 issued on the done cycle
        @(negedge clk);
        start_now(0, 0);
        wait_done(0, c);
        chk("bcd_0", bcd0, 12'h000);
        start_now(0, 99);
        wait_done(0, c);
        chk("b2b_lat", c, 9);
        chk("bcd_99", bcd0, 12'h099);

        // second start while busy is ignored
        @(negedge clk);
        start_now(0, 137);
        repeat (2) @(negedge clk);
        start_now(0, 1);
        wait_done(0, c);
        chk("ign_bcd", bcd0, 12'h137);
        count_dones(15, nd);
        chk("ign_single_done", nd, 0);

        // async reset mid-conversion
        start_now(0, 200);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_bcd",  bcd0,  0);
        chk("abort_ovf",  ovf0,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_dones(12, nd);
        chk("abort_no_done", nd, 0);
        start_now(0, 200);
        wait_done(0, c);
        chk("bcd_200", bcd0, 12'h200);

        // two-digit instance: overflow and recovery
        @(negedge clk);
        start_now(1, 200);
        wait_done(1, c);
        chk("d2_lat", c, 9);
        chk("d2_ovf_200", ovf1, 1);
        chk("d2_bcd_200", bcd1, 8'h00);
        @(negedge clk);
        start_now(1, 99);
        wait_done(1, c);
        chk("d2_ovf_99", ovf1, 0);
        chk("d2_bcd_99", bcd1, 8'h99);

        // leading-zero cases
        @(negedge clk);
        start_now(0, 7);
        wait_done(0, c);
        chk("bcd_7", bcd0, 12'h007);
`ifdef BCD_DD_BLANK_EN
        chk("blank_7", blank0, 3'b110);
`endif
        @(negedge clk);
        start_now(0, 0);
        wait_done(0, c);
        chk("bcd_0b", bcd0, 12'h000);
`ifdef BCD_DD_BLANK_EN
        chk("blank_0", blank0, 3'b110);
`endif
        @(negedge clk);
        start_now(0, 105);
        wait_done(0, c);
        chk("bcd_105", bcd0, 12'h105);
`ifdef BCD_DD_BLANK_EN
        chk("blank_105", blank0, 3'b000);
`endif

        // random traffic on both instances, one reset in the middle
        for (int i = 0; i < 800; i++) begin
            st[0] = ($urandom_range(0, 3) == 0);
            bv[0] = 8'($urandom);
            st[1] = ($urandom_range(0, 2) == 0);
            bv[1] = 8'($urandom);
            if (i == 400) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        st[0] = 1'b0;
        st[1] = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bcd_dd_seq
